// File: rtl/lvt_table_pkg.sv
// Shared types for the two-write-port LVT register file: bank selector encoding
// and default geometry used by the table, bank RAMs and word multiplexers.
package lvt_table_pkg;

  localparam int LVT_ENTRY_W   = 1;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 16;
  localparam int CNT_WIDTH_DEF  = 8;

  // Which write bank last wrote a register; drives the 2:1 word mux select.
  typedef enum logic [LVT_ENTRY_W-1:0] {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } lvt_entry_t;

endpackage

// File: rtl/lvt_sat_counter.sv
// Parameterised up-counter that stops at its all-ones value instead of wrapping.
module lvt_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (inc_i && (count_o != MAX_VAL)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lvt_table.sv
// Live value table: per-address record of the last writing bank, read out with
// the same one-cycle, read-first timing as the bank RAMs.
//
// Interface timing: there is no valid/ready handshake. Every input is sampled on
// every rising clk_i edge; writes are qualified only by we0_i/we1_i, reads are
// unconditional, and the block never stalls.
module lvt_table
  import lvt_table_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] waddr0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] waddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr0_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  output lvt_entry_t            sel0_o,
  output lvt_entry_t            sel1_o,
  output logic                  conflict_o,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  lvt_entry_t table_q [DEPTH];
  logic       conflict_d;

  assign conflict_d = we0_i && we1_i && (waddr0_i == waddr1_i);

  // Port 1 is written after port 0 so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= BANK_0;
      end
    end else begin
      if (we0_i) table_q[waddr0_i] <= BANK_0;
      if (we1_i) table_q[waddr1_i] <= BANK_1;
    end
  end

  // Reads sample the pre-write table contents, giving read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel0_o     <= BANK_0;
      sel1_o     <= BANK_0;
      conflict_o <= 1'b0;
    end else begin
      sel0_o     <= table_q[raddr0_i];
      sel1_o     <= table_q[raddr1_i];
      conflict_o <= conflict_d;
    end
  end

  lvt_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_conflict_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (conflict_d),
    .count_o (conflict_cnt_o)
  );

endmodule

// File: doc/lvt_table.md
# lvt_table

Live value table for the two-write-port LVT register file. Tracks, per register address, which write bank (BANK_0 or BANK_1) last wrote it, and on each read port produces the `LVT_ENTRY` selector that drives the downstream 2:1 word multiplexers. Read latency and read-during-write behaviour match the bank RAMs, so each selector arrives aligned with the bank data it chooses between.

## Interface
Parameters:
- ADDR_WIDTH, 4: register address width.
- DEPTH, 16: number of tracked registers (2**ADDR_WIDTH).
- CNT_WIDTH, 8: width of the write-conflict counter.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- we0_i  in  1  write enable, write port 0 (bank 0).
- waddr0_i  in  ADDR_WIDTH  write address, port 0.
- we1_i  in  1  write enable, write port 1 (bank 1).
- waddr1_i  in  ADDR_WIDTH  write address, port 1.
- raddr0_i  in  ADDR_WIDTH  read address, read port 0.
- raddr1_i  in  ADDR_WIDTH  read address, read port 1.
- sel0_o  out  `LVT_ENTRY  registered bank selector for read port 0.
- sel1_o  out  `LVT_ENTRY  registered bank selector for read port 1.
- conflict_o  out  1  registered pulse: both ports wrote the same address last cycle.
- conflict_cnt_o  out  CNT_WIDTH  saturating count of conflicts since reset.

## Operation
- Table: DEPTH entries of `LVT_ENTRY, flop-based.
- Write: we0_i alone → entry[waddr0_i] := `BANK_0. we1_i alone → entry[waddr1_i] := `BANK_1. Both, different addresses → both updated independently.
- Write conflict (we0_i & we1_i & waddr0_i == waddr1_i): port 1 wins, entry := `BANK_1; conflict_o asserted the following cycle for one cycle; conflict_cnt_o increments, saturating at 2**CNT_WIDTH-1 (no wrap).
- Read: sel0_o := entry[raddr0_i], sel1_o := entry[raddr1_i], sampled every cycle (no read enable).
- Read-during-write to same address: read-first; the selector reflects the entry value before the write, matching the read-first bank RAMs. The new value is visible to a read issued the next cycle.
- Both read ports may address the same entry; both return the same value.
- Reset (rst_ni == 0 at a clock edge): all entries := `BANK_0, sel0_o = sel1_o = `BANK_0, conflict_o = 0, conflict_cnt_o = 0. Writes and conflicts in a reset cycle are discarded. Reset mid-stream is a complete clear; no pending state survives.
- No state machine beyond the table, output registers and counter; no stalls or backpressure.

## Timing
- Write → table update: 1 cycle (visible to reads issued the cycle after the write).
- Read address → sel*_o: 1 cycle, registered.
- Conflict → conflict_o: 1 cycle; conflict_cnt_o updates on the same edge as conflict_o rises.
- First cycle after reset deassertion: outputs hold reset values until the first sampled read.

## Structure
- `LVT_ENTRY, `BANK_0, `BANK_1 and the address width belong in the shared parameters.v include, shared with the bank RAMs and the word multiplexer.
- Single module. One natural sub-module: lvt_sat_counter (parameterised saturating counter) for conflict_cnt_o.

## Test plan
- Reset, then read all 16 addresses on both ports → every sel = `BANK_0; conflict_cnt_o = 0.
- Cycle 0 write port 0 addr 3, cycle 1 write port 1 addr 3, read addr 3 from cycle 2 → sel = `BANK_1; read of addr 3 issued in cycle 1 (same cycle as the port-1 write) → `BANK_0 (read-first).
- Same cycle: we0 addr 5, we1 addr 5 → next cycle conflict_o = 1 for exactly one cycle, conflict_cnt_o = 1; later read of addr 5 → `BANK_1.
- Same cycle: we0 addr 2, we1 addr 9 → no conflict; reads → entry 2 = `BANK_0, entry 9 = `BANK_1.
- 300 consecutive same-address dual writes → conflict_cnt_o stops at 255 and holds.
- Populate several entries with `BANK_1, assert rst_ni low for one cycle mid-write → all entries read `BANK_0; conflict_cnt_o = 0; the write in the reset cycle is not retained.
